// File: rtl/decoder_pkg.sv
// Shared constants for the decoder select sequencer and the decoders it drives.
package decoder_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DWELL = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int SEL_WIDTH_DEF   = 3;
  localparam int DWELL_WIDTH_DEF = 8;
endpackage

// File: rtl/decoder_scan_sequencer_dwell_counter.sv
// Per-channel dwell countdown; expire is high on the last cycle of a loaded dwell.
// value must be nonzero; a load in the expiring cycle starts the next dwell with no gap.
module dwell_counter #(
  parameter int DWELL_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   clear,
  input  logic [DWELL_WIDTH-1:0] value,
  output logic                   expire
);
  logic [DWELL_WIDTH-1:0] cnt_q;
  logic                   run_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (clear) begin
      run_q <= 1'b0;
    end else if (load) begin
      cnt_q <= value - DWELL_WIDTH'(1);
      run_q <= 1'b1;
    end else if (run_q) begin
      if (cnt_q == '0) run_q <= 1'b0;
      else             cnt_q <= cnt_q - DWELL_WIDTH'(1);
    end
  end

  assign expire = run_q && (cnt_q == '0);
endmodule

// File: rtl/decoder_scan_sequencer.sv
// Steps a registered decoder select through a latched channel range, holding each channel
// for a programmed dwell; single-shot or continuous, with stop taking priority over all but reset.
module decoder_scan_sequencer
  import decoder_pkg::*;
#(
  parameter int SEL_WIDTH   = SEL_WIDTH_DEF,
  parameter int DWELL_WIDTH = DWELL_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   continuous,
  input  logic [SEL_WIDTH-1:0]   first_sel,
  input  logic [SEL_WIDTH-1:0]   last_sel,
  input  logic [DWELL_WIDTH-1:0] dwell,
  output logic [SEL_WIDTH-1:0]   sel_out,
  output logic                   sel_en,
  output logic                   step_pulse,
  output logic                   busy,
  output logic                   done
);
  logic [1:0]             state_q, state_d;
  logic [SEL_WIDTH-1:0]   sel_q, sel_d, first_q, first_d, last_q, last_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d, cnt_value;
  logic                   en_q, en_d, step_q, step_d, busy_q, busy_d, done_q, done_d;
  logic                   cnt_load, cnt_clear, expire;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    first_d   = first_q;
    last_d    = last_q;
    dwell_d   = dwell_q;
    en_d      = en_q;
    step_d    = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cnt_load  = 1'b0;
    cnt_clear = 1'b0;
    cnt_value = dwell_q;
    case (state_q)
      ST_IDLE: begin
        en_d   = 1'b0;
        busy_d = 1'b0;
        if (start && !stop) begin
          // A zero dwell is promoted to one cycle so every channel is seen.
          dwell_d   = (dwell == '0) ? DWELL_WIDTH'(1) : dwell;
          cnt_value = dwell_d;
          cnt_load  = 1'b1;
          first_d   = first_sel;
          last_d    = last_sel;
          sel_d     = first_sel;
          state_d   = ST_DWELL;
          en_d      = 1'b1;
          step_d    = 1'b1;
          busy_d    = 1'b1;
        end
      end
      ST_DWELL: begin
        if (stop) begin
          cnt_clear = 1'b1;
          state_d   = ST_IDLE;
          en_d      = 1'b0;
          busy_d    = 1'b0;
        end else if (expire) begin
          if (sel_q != last_q) begin
            sel_d    = sel_q + SEL_WIDTH'(1);
            step_d   = 1'b1;
            cnt_load = 1'b1;
          end else if (continuous) begin
            sel_d    = first_q;
            step_d   = 1'b1;
            cnt_load = 1'b1;
          end else begin
            state_d = ST_DONE;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
      dwell_q <= '0;
      en_q    <= 1'b0;
      step_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      first_q <= first_d;
      last_q  <= last_d;
      dwell_q <= dwell_d;
      en_q    <= en_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  dwell_counter #(.DWELL_WIDTH(DWELL_WIDTH)) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (cnt_load),
    .clear  (cnt_clear),
    .value  (cnt_value),
    .expire (expire)
  );

  assign sel_out    = sel_q;
  assign sel_en     = en_q;
  assign step_pulse = step_q;
  assign busy       = busy_q;
  assign done       = done_q;
endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Directed bench for decoder_scan_sequencer; outputs are sampled 1ns after each rising edge.
module tb_decoder_scan_sequencer;
  logic       clk = 1'b0;
  logic       rst_n, start, stop, continuous;
  logic [2:0] first_sel, last_sel, sel_out;
  logic [7:0] dwell;
  logic       sel_en, step_pulse, busy, done;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  decoder_scan_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .first_sel  (first_sel),
    .last_sel   (last_sel),
    .dwell      (dwell),
    .sel_out    (sel_out),
    .sel_en     (sel_en),
    .step_pulse (step_pulse),
    .busy       (busy),
    .done       (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packed as {sel_out, sel_en, step_pulse, busy, done}.
  task automatic chk_out(input string tag, input logic [2:0] s, input logic e,
                         input logic p, input logic b, input logic d);
    chk(tag, {25'd0, sel_out, sel_en, step_pulse, busy, done}, {25'd0, s, e, p, b, d});
  endtask

  task automatic chk_onehot(input string tag, input logic [7:0] exp);
    logic [7:0] dec;
    dec = sel_en ? (8'b0000_0001 << sel_out) : 8'b0;
    chk(tag, {24'd0, dec}, {24'd0, exp});
  endtask

  task automatic launch(input logic [2:0] f, input logic [2:0] l, input logic [7:0] d,
                        input logic c);
    first_sel  = f;
    last_sel   = l;
    dwell      = d;
    continuous = c;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  initial begin
    logic seen;
    logic [2:0] wrap_seq [7];
    wrap_seq = '{3'd6, 3'd7, 3'd0, 3'd1, 3'd6, 3'd7, 3'd0};
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    first_sel = 3'd0; last_sel = 3'd0; dwell = 8'd0;
    step();
    step();
    chk_out("reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    chk_out("idle_after_reset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Full 0..7 scan, dwell 2: done lands at T+17.
    launch(3'd0, 3'd7, 8'd2, 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk_out($sformatf("basic_c%0d", i + 1), 3'(i / 2), 1'b1, (i % 2) == 0, 1'b1, 1'b0);
      step();
    end
    chk_out("basic_done", 3'd7, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk_out("basic_idle", 3'd7, 1'b0, 1'b0, 1'b0, 1'b0);

    // Single channel, zero dwell treated as one cycle.
    launch(3'd5, 3'd5, 8'd0, 1'b0);
    chk_out("single_ch", 3'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    chk_onehot("single_onehot", 8'b0010_0000);
    step();
    chk_out("single_done", 3'd5, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_onehot("done_onehot", 8'b0000_0000);
    step();
    chk_out("single_idle", 3'd5, 1'b0, 1'b0, 1'b0, 1'b0);

    // Wrapped range 6..1 in continuous mode, then single-shot exit.
    launch(3'd6, 3'd1, 8'd1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      chk_out($sformatf("wrap_c%0d", i + 1), wrap_seq[i], 1'b1, 1'b1, 1'b1, 1'b0);
      if (i == 6) continuous = 1'b0;
      step();
    end
    chk_out("wrap_last", 3'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    step();
    chk_out("wrap_done", 3'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    step();

    // Abort during channel 3.
    launch(3'd0, 3'd7, 8'd2, 1'b0);
    for (int i = 0; i < 6; i++) step();
    chk_out("abort_ch3", 3'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_out("abort_next", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done || busy || sel_en) seen = 1'b1;
    end
    chk("abort_quiet", {31'd0, seen}, 32'd0);

    // start together with stop in IDLE is refused.
    first_sel = 3'd2; last_sel = 3'd4; dwell = 8'd1;
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk_out("startstop_idle", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_out("startstop_idle2", 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);

    // start mid-scan with new settings is ignored; 2..4 at dwell 3 finishes at T+10.
    launch(3'd2, 3'd4, 8'd3, 1'b0);
    step();
    step();
    first_sel = 3'd0; last_sel = 3'd7; dwell = 8'd1; start = 1'b1;
    step();
    start = 1'b0;
    chk_out("ignored_T4", 3'd3, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step();
    chk_out("ignored_T9", 3'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    chk_out("ignored_done", 3'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    step();

    // Reset mid-dwell clears everything with no done.
    launch(3'd1, 3'd6, 8'd4, 1'b0);
    step();
    chk_onehot("scan_onehot", 8'b0000_0010);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk_out("midreset", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk_out("midreset_idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
